// File: rtl/obuf_drain.sv
// obuf_drain: output end of the conv datapath.
// Captures pe_array result words (acc + obuf_write_data) into a small FIFO and
// serializes each word into signed ACCU_WIDTH lanes on a valid/ready stream.
// Counts captured/drained words against num_total_conv latched on start.
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   enable                gates capture of acc only (draining never stalls)
//   start                 1-cycle pulse: clear state, latch num_kernel/num_total_conv
//   num_kernel            valid lanes per word (clamped to MAX_KERNELNUM)
//   num_total_conv        result words expected this layer
//   acc, obuf_write_data  result word valid / payload
//   out_valid/out_ready   stream handshake
//   out_data, out_lane    current lane payload and index
//   out_last              final lane of final word
//   fifo_count            words held
//   overflow, done        sticky flags
module obuf_drain #(
    parameter int MAX_KERNELNUM   = 8,
    parameter int ACCU_WIDTH      = 24,
    parameter int OBUF_DATA_WIDTH = MAX_KERNELNUM * ACCU_WIDTH,
    parameter int KERNELNUM_WIDTH = $clog2(MAX_KERNELNUM) + 1,
    parameter int TIMESTEP_WIDTH  = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           start,
    input  logic [KERNELNUM_WIDTH-1:0]     num_kernel,
    input  logic [TIMESTEP_WIDTH-1:0]      num_total_conv,
    input  logic                           acc,
    input  logic [OBUF_DATA_WIDTH-1:0]     obuf_write_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACCU_WIDTH-1:0]          out_data,
    output logic [KERNELNUM_WIDTH-1:0]     out_lane,
    output logic                           out_last,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           overflow,
    output logic                           done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [OBUF_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [CW-1:0]              count;
    logic [KERNELNUM_WIDTH-1:0] nk_q, lane, nk_clamp;
    logic [TIMESTEP_WIDTH-1:0]  ntc_q, cap_cnt, drain_cnt;
    logic [ACCU_WIDTH-1:0]      lane_data;
    logic run_ok, accept, last_lane, last_word, pop, fin, cap_req, push, drop;

    // A layer with zero lanes or zero words produces no stream at all.
    assign run_ok    = (nk_q != '0) && (ntc_q != '0);
    assign accept    = out_valid && out_ready;
    assign last_lane = (lane == KERNELNUM_WIDTH'(nk_q - 1'b1));
    assign last_word = (drain_cnt == TIMESTEP_WIDTH'(ntc_q - 1'b1));
    assign pop       = accept && last_lane;
    assign fin       = pop && last_word;

    // start wins over a same-cycle acc; that word is silently dropped.
    assign cap_req = (state == RUN) && acc && enable && !start;
    // A full FIFO still takes a word when the head word leaves this cycle.
    assign push    = cap_req && run_ok && (cap_cnt < ntc_q) &&
                     ((count != CW'(FIFO_DEPTH)) || pop);
    assign drop    = cap_req && !push;

    assign nk_clamp   = (num_kernel > KERNELNUM_WIDTH'(MAX_KERNELNUM)) ?
                        KERNELNUM_WIDTH'(MAX_KERNELNUM) : num_kernel;
    assign fifo_count = count;
    assign out_lane   = lane;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = RUN;
        end else begin
            case (state)
                RUN:     if (!run_ok || fin) state_nx = DONE;
                default: state_nx = state;
            endcase
        end
    end

    // Head-word lane select
    always_comb begin
        lane_data = '0;
        for (int k = 0; k < MAX_KERNELNUM; k++)
            if (lane == KERNELNUM_WIDTH'(k))
                lane_data = mem[rd_ptr][k*ACCU_WIDTH +: ACCU_WIDTH];
    end

    // FSM: outputs
    always_comb begin
        out_valid = (state == RUN) && run_ok && (count != '0);
        out_last  = out_valid && last_lane && last_word;
        out_data  = out_valid ? lane_data : '0;
    end

    // Word storage carries no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= obuf_write_data;
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            lane      <= '0;
            cap_cnt   <= '0;
            drain_cnt <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
            nk_q      <= reset ? '0 : nk_clamp;
            ntc_q     <= reset ? '0 : num_total_conv;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                cap_cnt <= cap_cnt + 1'b1;
            end
            if (accept) lane <= last_lane ? '0 : lane + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                drain_cnt <= drain_cnt + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
            if ((state == RUN) && (!run_ok || fin)) done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_obuf_drain.sv
module tb_obuf_drain;
    localparam int NK = 8, AW = 24, DW = NK * AW, KW = 4, TW = 8, DEPTH = 4;

    logic clk = 0, reset = 1, enable = 0, start = 0, acc = 0, out_ready = 0;
    logic [KW-1:0] num_kernel = 0;
    logic [TW-1:0] num_total_conv = 0;
    logic [DW-1:0] obuf_write_data = '0;
    logic out_valid, out_last, overflow, done;
    logic [AW-1:0] out_data;
    logic [KW-1:0] out_lane;
    logic [2:0]    fifo_count;

    obuf_drain dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .num_kernel(num_kernel), .num_total_conv(num_total_conv),
        .acc(acc), .obuf_write_data(obuf_write_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last), .fifo_count(fifo_count),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // Behavioural reference: a queue of words plus layer bookkeeping.
    logic [DW-1:0] q[$];
    bit m_run, m_done, m_ovf;
    int m_lane, m_cap, m_drn, m_nk, m_ntc;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete(); m_run = 0; m_done = 0; m_ovf = 0;
        m_lane = 0; m_cap = 0; m_drn = 0;
    endtask

    task automatic model_step();
        int sz;
        bit popped, fin;
        if (reset) begin model_clear(); m_nk = 0; m_ntc = 0; return; end
        if (start) begin
            model_clear(); m_run = 1;
            m_nk = (int'(num_kernel) > NK) ? NK : int'(num_kernel);
            m_ntc = int'(num_total_conv);
            return;
        end
        if (!m_run) return;
        if (m_nk == 0 || m_ntc == 0) begin
            if (acc && enable) m_ovf = 1;
            m_run = 0; m_done = 1;
            return;
        end
        sz = q.size(); popped = 0; fin = 0;
        if (sz > 0 && out_ready) begin
            if (m_lane == m_nk - 1) begin
                popped = 1; fin = (m_drn == m_ntc - 1);
                void'(q.pop_front()); m_drn++; m_lane = 0;
            end else m_lane++;
        end
        if (acc && enable) begin
            if (m_cap < m_ntc && (sz < DEPTH || popped)) begin
                q.push_back(obuf_write_data); m_cap++;
            end else m_ovf = 1;
        end
        if (fin) begin m_run = 0; m_done = 1; end
    endtask

    task automatic model_check();
        bit ev, el;
        logic [AW-1:0] ed;
        ev = m_run && q.size() > 0;
        el = ev && (m_lane == m_nk - 1) && (m_drn == m_ntc - 1);
        ed = ev ? q[0][m_lane*AW +: AW] : '0;
        check("mdl_valid", 64'(out_valid), 64'(ev));
        check("mdl_last", 64'(out_last), 64'(el));
        check("mdl_data", 64'(out_data), 64'(ed));
        check("mdl_lane", 64'(out_lane), 64'(m_lane));
        check("mdl_count", 64'(fifo_count), 64'(q.size()));
        check("mdl_ovf", 64'(overflow), 64'(m_ovf));
        check("mdl_done", 64'(done), 64'(m_done));
    endtask

    // Inputs are stable around the edge; outputs sampled on the falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    task automatic do_start(int nk, int ntc);
        start = 1; num_kernel = KW'(nk); num_total_conv = TW'(ntc);
        tick();
        start = 0;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    typedef struct {
        int nk;
        int exp_lanes;
    } vec_t;

    initial begin
        vec_t vt[5];
        logic [DW-1:0] w;
        int lanes, lastidx;

        vt[0] = '{1, 1};
        vt[1] = '{8, 8};
        vt[2] = '{12, 8};
        vt[3] = '{3, 3};
        vt[4] = '{0, 0};

        @(negedge clk);
        tick(); tick();
        reset = 0;
        check("rst_valid", 64'(out_valid), 0);
        check("rst_data", 64'(out_data), 0);
        check("rst_lane", 64'(out_lane), 0);
        check("rst_last", 64'(out_last), 0);
        check("rst_count", 64'(fifo_count), 0);
        check("rst_ovf", 64'(overflow), 0);
        check("rst_done", 64'(done), 0);

        // T1: two lanes {-5, 7}, one word
        enable = 1; out_ready = 1;
        do_start(2, 1);
        w = '0; w[23:0] = 24'hFFFFFB; w[47:24] = 24'd7;
        acc = 1; obuf_write_data = w; tick(); acc = 0;
        check("t1_l0_valid", 64'(out_valid), 1);
        check("t1_l0_data", 64'(out_data), 64'h0FFFFFB);
        check("t1_l0_lane", 64'(out_lane), 0);
        tick();
        check("t1_l1_data", 64'(out_data), 7);
        check("t1_l1_lane", 64'(out_lane), 1);
        check("t1_l1_last", 64'(out_last), 1);
        tick();
        check("t1_done", 64'(done), 1);
        check("t1_ovf", 64'(overflow), 0);
        check("t1_valid_off", 64'(out_valid), 0);

        // Table: one word per layer, lanes streamed = clamped num_kernel
        foreach (vt[i]) begin
            out_ready = 0;
            do_start(vt[i].nk, 1);
            acc = 1; obuf_write_data = rnd_word(); tick(); acc = 0;
            out_ready = 1; lanes = 0;
            for (int c = 0; c < 20; c++) begin
                if (out_valid && out_ready) lanes++;
                tick();
            end
            check("tbl_lanes", 64'(lanes), 64'(vt[i].exp_lanes));
            check("tbl_done", 64'(done), 1);
        end

        // T2: nk=8, ntc=3, ready toggling
        out_ready = 0;
        do_start(8, 3);
        lanes = 0; lastidx = 0;
        for (int c = 0; c < 80; c++) begin
            out_ready = (c % 2) == 1;
            acc = (c < 3); obuf_write_data = rnd_word();
            if (out_valid && out_ready) begin
                lanes++;
                if (out_last) lastidx = lanes;
            end
            tick();
        end
        acc = 0;
        check("t2_lanes", 64'(lanes), 24);
        check("t2_lastidx", 64'(lastidx), 24);
        check("t2_done", 64'(done), 1);

        // T3: overfill with ready low
        out_ready = 0;
        do_start(2, 6);
        acc = 1;
        for (int c = 0; c < 6; c++) begin obuf_write_data = rnd_word(); tick(); end
        acc = 0;
        check("t3_count", 64'(fifo_count), 4);
        check("t3_ovf", 64'(overflow), 1);
        out_ready = 1; lanes = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && out_ready) lanes++;
            tick();
        end
        check("t3_lanes", 64'(lanes), 8);
        check("t3_done", 64'(done), 0);
        check("t3_empty", 64'(fifo_count), 0);

        // T4: full FIFO, last-lane accept coincides with acc
        out_ready = 0;
        do_start(2, 8);
        acc = 1;
        for (int c = 0; c < 4; c++) begin obuf_write_data = rnd_word(); tick(); end
        acc = 0; out_ready = 1; tick();
        acc = 1; obuf_write_data = rnd_word(); tick();
        acc = 0; out_ready = 0;
        check("t4_count", 64'(fifo_count), 4);
        check("t4_ovf", 64'(overflow), 0);
        for (int c = 0; c < 3; c++) tick();

        // T5: ntc=0
        do_start(3, 0);
        check("t5_valid0", 64'(out_valid), 0);
        tick();
        check("t5_done", 64'(done), 1);
        check("t5_valid1", 64'(out_valid), 0);
        acc = 1; obuf_write_data = rnd_word(); tick(); acc = 0;
        check("t5_ign_count", 64'(fifo_count), 0);
        check("t5_ign_ovf", 64'(overflow), 0);

        // T6: restart mid-stream, then reset mid-stream
        out_ready = 0;
        do_start(4, 5);
        acc = 1;
        for (int c = 0; c < 2; c++) begin obuf_write_data = rnd_word(); tick(); end
        acc = 0;
        check("t6_pre_count", 64'(fifo_count), 2);
        do_start(3, 2);
        check("t6_count", 64'(fifo_count), 0);
        check("t6_valid", 64'(out_valid), 0);
        check("t6_done", 64'(done), 0);
        check("t6_ovf", 64'(overflow), 0);
        acc = 1; obuf_write_data = rnd_word(); tick(); acc = 0;
        out_ready = 1; lanes = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid && out_ready) lanes++;
            tick();
        end
        check("t6_newnk_lanes", 64'(lanes), 3);
        acc = 1; obuf_write_data = rnd_word(); out_ready = 0; tick(); acc = 0;
        reset = 1; tick(); reset = 0;
        check("t6_rst_count", 64'(fifo_count), 0);
        check("t6_rst_valid", 64'(out_valid), 0);
        check("t6_rst_lane", 64'(out_lane), 0);
        check("t6_rst_done", 64'(done), 0);
        check("t6_rst_ovf", 64'(overflow), 0);

        // Randomized layers against the reference model
        for (int r = 0; r < 6; r++) begin
            out_ready = 0;
            do_start(int'($urandom_range(1, 10)), int'($urandom_range(1, 12)));
            for (int c = 0; c < 120; c++) begin
                acc = ($urandom_range(0, 1) == 1);
                enable = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 4) < 3);
                obuf_write_data = rnd_word();
                tick();
            end
            acc = 0; enable = 1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
